addr_result_fifo: RTL and testbench
===================================

Name: addr_result_fifo

Overview:
Downstream capture buffer for the 8-bit adder stage. It takes one {carry, sum} result on every cycle the adder's result-valid output is high and stores it in a small first-word-fall-through FIFO. Results are presented to the consumer with a valid/take handshake. Results arriving while the buffer is full are dropped and counted; a sticky overflow flag records that drops occurred.

Parameters:
DEPTH, 4, number of stored entries; must be a power of two and at least 2
DATA_W, 8, width of the sum field; one carry bit is added to form each entry
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  clock; all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
in_sum  input  DATA_W  sum result from the adder stage
in_carry  input  1  carry-out from the adder stage
in_ready  input  1  adder result-valid; each high cycle is one new result
out_data  output  DATA_W+1  head entry, carry in the MSB and sum in the LSBs; 0 when empty
out_valid  output  1  head entry is present
out_take  input  1  consumer pops the head entry this cycle
full  output  1  level equals DEPTH
empty  output  1  level equals 0
level  output  clog2(DEPTH)+1  number of stored entries
overflow  output  1  sticky: set when at least one result has been dropped
drop_count  output  CNT_W  number of dropped results, saturating
clr_overflow  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (reset_n low, asynchronous): pointers, level, overflow and drop_count go to 0; empty=1, full=0, out_valid=0, out_data=0. Storage contents are don't-care. Reset asserted mid-stream discards all entries immediately.
- Pointers: rd_ptr and wr_ptr, each clog2(DEPTH)+1 bits including a wrap bit.
  - empty when the two pointers are equal.
  - full when the index bits are equal and the wrap bits differ.
  - level = wr_ptr - rd_ptr, modulo 2^(clog2(DEPTH)+1).
- pop = out_valid & out_take. out_take while empty is ignored.
- push = in_ready & (!full | pop).
  - The entry is written at wr_ptr, and wr_ptr increments on the clock edge.
  - Full with a simultaneous pop: the push is accepted, level stays at DEPTH, no drop occurs.
- Empty with push and out_take in the same cycle: no pop. The new entry appears on out_data with out_valid=1 on the next cycle. Fall-through latency from push to visible is 1 cycle.
- Output is first-word-fall-through: out_data = storage[rd_ptr index] whenever out_valid=1, otherwise 0. After a pop, the next entry is visible in the following cycle.
- Drop: in_ready & full & !pop.
  - The result is discarded; storage and pointers are unchanged.
  - overflow is set to 1.
  - drop_count increments and saturates at 2^CNT_W-1.
- clr_overflow: on the next edge, overflow=0 and drop_count=0.
  - If a drop happens in the same cycle, the set wins: overflow=1, drop_count=1.
- full, empty, out_valid and level are derived from the registered pointers only. There is no combinational path from in_ready to these outputs.
- Pointer wrap: both pointers wrap modulo 2^(clog2(DEPTH)+1); ordering is preserved across the wrap.

Decomposition:
- Shared package: ENTRY_W = DATA_W+1; the entry field positions (CARRY_BIT = DATA_W, SUM_LSB = 0); a clog2 helper function.
- One natural sub-module, addr_fifo_ctrl: pointers, full/empty/level logic, push/pop qualification.
- Storage array, output mux and the overflow/drop counter stay in the top module.

Test Plan:
- Reset: drive reset_n low asynchronously between clock edges -> empty=1, full=0, out_valid=0, out_data=0x000, level=0, overflow=0, drop_count=0 immediately, without waiting for a clock edge.
- Single entry: in_sum=0x2A, in_carry=0, in_ready high for 1 cycle -> next cycle out_valid=1, out_data=0x02A, level=1; out_take for 1 cycle -> empty=1, level=0.
- Fill and drop, out_take=0 throughout:
  - Push (0x10,c0), (0x20,c1), (0x30,c0), (0x40,c1) -> full=1, level=4.
  - 5th push 0x50 -> overflow=1, drop_count=1.
  - Drain -> outputs 0x010, 0x120, 0x030, 0x140 in that order; 0x50 never appears.
- Full with simultaneous push and pop: when full, push (0x99,c0) with out_take=1 -> level stays 4, overflow unchanged, no drop; 0x099 emerges last after the three remaining entries.
- Wrap and streaming: in_ready and out_take held high for 10 cycles with sums 0x01..0x0A -> outputs 0x001..0x00A in order, level never exceeds 1, pointers wrap without loss.
- Saturation and clear: hold full and drive 300 dropped pushes -> drop_count=255. Then assert clr_overflow in the same cycle as one more drop -> overflow=1, drop_count=1. clr_overflow alone on the next cycle -> overflow=0, drop_count=0.

Source files
------------

// File: rtl/addr_result_fifo_pkg.sv
// rtl/addr_result_fifo_pkg.sv - shared parameters, entry layout and clog2 helper for the adder result FIFO
//
// Purpose: default sizes, the {carry, sum} entry field positions and a
// constant-evaluable clog2 used to size pointers and the level output.

package addr_result_fifo_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  // Entry layout: carry sits directly above the sum field.
  localparam int ENTRY_W   = DEF_DATA_W + 1;
  localparam int CARRY_BIT = DEF_DATA_W;
  localparam int SUM_LSB   = 0;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addr_result_fifo_if.sv
// rtl/addr_result_fifo_if.sv - producer/consumer/status bundle of the adder result FIFO
//
// Purpose: groups every FIFO signal except clk/reset_n.
// Ports (slave = FIFO side):
//   in_sum, in_carry, in_ready      adder result and its valid strobe
//   out_data, out_valid, out_take   FWFT head entry and pop handshake
//   full, empty, level              occupancy status
//   overflow, drop_count            sticky drop flag and saturating drop count
//   clr_overflow                    synchronous clear of the drop status

interface addr_result_fifo_if #(
  parameter int DATA_W = addr_result_fifo_pkg::DEF_DATA_W,
  parameter int CNT_W  = addr_result_fifo_pkg::DEF_CNT_W,
  parameter int DEPTH  = addr_result_fifo_pkg::DEF_DEPTH
);
  localparam int LVL_W = addr_result_fifo_pkg::clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_sum;
  logic              in_carry;
  logic              in_ready;
  logic [DATA_W:0]   out_data;
  logic              out_valid;
  logic              out_take;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic              clr_overflow;

  modport master (
    output in_sum, in_carry, in_ready, out_take, clr_overflow,
    input  out_data, out_valid, full, empty, level, overflow, drop_count
  );

  modport slave (
    input  in_sum, in_carry, in_ready, out_take, clr_overflow,
    output out_data, out_valid, full, empty, level, overflow, drop_count
  );

endinterface

// File: rtl/addr_fifo_ctrl.sv
// rtl/addr_fifo_ctrl.sv - pointer, occupancy and push/pop qualification for the adder result FIFO
//
// Purpose: keeps wrap-bit read/write pointers and derives status from them.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_ready, out_take    raw write strobe and consumer take
//   push, pop, drop       qualified write, qualified read, rejected write
//   wr_idx, rd_idx        storage indices for write and head read
//   full, empty, out_valid, level   status from registered pointers only

module addr_fifo_ctrl
  import addr_result_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_ready,
  input  logic             out_take,
  output logic             push,
  output logic             pop,
  output logic             drop,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx,
  output logic             full,
  output logic             empty,
  output logic             out_valid,
  output logic [PTR_W-1:0] level
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign wr_idx    = wr_ptr[IDX_W-1:0];
  assign rd_idx    = rd_ptr[IDX_W-1:0];

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign level     = wr_ptr - rd_ptr;
  assign out_valid = !empty;

  assign pop       = out_valid & out_take;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
  assign push      = in_ready & (!full | pop);
  assign drop      = in_ready & full & !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/addr_result_fifo.sv
// rtl/addr_result_fifo.sv - FWFT capture FIFO for {carry, sum} adder results with drop accounting
//
// Purpose: stores one adder result per in_ready cycle, presents the head with
// a valid/take handshake, and counts results rejected while full.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      addr_result_fifo_if.slave (input stream, output stream, status)

module addr_result_fifo
  import addr_result_fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  addr_result_fifo_if.slave   bus
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int E_W   = DATA_W + 1;
  localparam int C_BIT = DATA_W;

  logic             push;
  logic             pop;
  logic             drop;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [PTR_W-1:0] level;
  logic [E_W-1:0]   wr_entry;
  logic [E_W-1:0]   mem [DEPTH];
  logic             overflow_q;
  logic [CNT_W-1:0] drop_count_q;

  addr_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_ready  (bus.in_ready),
    .out_take  (bus.out_take),
    .push      (push),
    .pop       (pop),
    .drop      (drop),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx),
    .full      (bus.full),
    .empty     (bus.empty),
    .out_valid (bus.out_valid),
    .level     (level)
  );

  assign bus.level = level;

  always_comb begin
    wr_entry                   = '0;
    wr_entry[C_BIT]            = bus.in_carry;
    wr_entry[C_BIT-1:SUM_LSB]  = bus.in_sum;
  end

  // Storage holds no reset: contents are only observed through out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= wr_entry;
  end

  assign bus.out_data = bus.out_valid ? mem[rd_idx] : '0;

  // A drop coinciding with a clear wins: the clear is overridden and this drop is counted as the first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (bus.clr_overflow)
        drop_count_q <= CNT_W'(1);
      else if (drop_count_q != {CNT_W{1'b1}})
        drop_count_q <= drop_count_q + CNT_W'(1);
    end else if (bus.clr_overflow) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end
  end

  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_addr_result_fifo.sv
// tb/tb_addr_result_fifo.sv - self-checking bench for addr_result_fifo against a queue model

module tb_addr_result_fifo;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  addr_result_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  addr_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] mq[$];
  logic       m_ovf = 1'b0;
  int         m_cnt = 0;

  function automatic logic [8:0] m_head();
    return (mq.size() > 0) ? mq[0] : 9'h000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Applies one cycle of inputs from a negedge, advances the model at the posedge, returns at the next negedge.
  task automatic cycle(input bit rdy, input logic [7:0] s, input bit c, input bit take, input bit clr);
    bit m_full, m_pop, m_push, m_drop;
    bus.in_ready = rdy; bus.in_sum = s; bus.in_carry = c;
    bus.out_take = take; bus.clr_overflow = clr;
    m_pop  = take && (mq.size() > 0);
    m_full = (mq.size() == DEPTH);
    m_push = rdy && (!m_full || m_pop);
    m_drop = rdy && m_full && !m_pop;
    @(posedge clk);
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back({c, s});
    if (m_drop) begin
      m_ovf = 1'b1;
      if (clr) m_cnt = 1;
      else if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    @(negedge clk);
    bus.in_ready = 1'b0; bus.out_take = 1'b0; bus.clr_overflow = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 1, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h44, 1, 0, 0);
    cycle(1, 8'h55, 0, 0, 0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_overflow got=%b exp=1", bus.overflow); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 9'h000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=000", bus.out_data); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    n_checks++; if (bus.drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count got=%0d exp=0", bus.drop_count); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    cycle(1, 8'h2A, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 9'h02A) begin n_fail++; $display("FAIL single_data got=%h exp=02a", bus.out_data); end
    n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", bus.level); end
    cycle(0, 8'h00, 0, 1, 0);
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got=%b exp=1", bus.empty); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL single_level_after got=%0d exp=0", bus.level); end
  endtask

  task automatic test_fill_drop();
    logic [8:0] exp_seq [4];
    exp_seq[0] = 9'h010; exp_seq[1] = 9'h120; exp_seq[2] = 9'h030; exp_seq[3] = 9'h140;
    cycle(1, 8'h10, 0, 0, 0);
    cycle(1, 8'h20, 1, 0, 0);
    cycle(1, 8'h30, 0, 0, 0);
    cycle(1, 8'h40, 1, 0, 0);
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fill_level got=%0d exp=4", bus.level); end
    cycle(1, 8'h50, 0, 0, 0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow got=%b exp=1", bus.overflow); end
    n_checks++; if (bus.drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count got=%0d exp=1", bus.drop_count); end
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL drop_level got=%0d exp=4", bus.level); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_data !== exp_seq[i]) begin n_fail++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.out_data, exp_seq[i]); end
      cycle(0, 8'h00, 0, 1, 0);
    end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] last;
    cycle(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 1'($urandom), 0, 0);
    cycle(1, 8'h99, 0, 1, 0);
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fpp_level got=%0d exp=4", bus.level); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got=%b exp=0", bus.overflow); end
    n_checks++; if (bus.drop_count !== 8'd0) begin n_fail++; $display("FAIL fpp_drop_count got=%0d exp=0", bus.drop_count); end
    last = 9'h000;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_data !== m_head()) begin n_fail++; $display("FAIL fpp_drain_%0d got=%h exp=%h", i, bus.out_data, m_head()); end
      last = bus.out_data;
      cycle(0, 8'h00, 0, 1, 0);
    end
    n_checks++; if (last !== 9'h099) begin n_fail++; $display("FAIL fpp_last got=%h exp=099", last); end
  endtask

  task automatic test_stream();
    logic [8:0] got[$];
    for (int i = 1; i <= 10; i++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
      cycle(1, 8'(i), 0, 1, 0);
      n_checks++; if (bus.level > 3'd1) begin n_fail++; $display("FAIL stream_level_%0d got=%0d exp<=1", i, bus.level); end
    end
    if (bus.out_valid === 1'b1) got.push_back(bus.out_data);
    cycle(0, 8'h00, 0, 1, 0);
    n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL stream_count got=%0d exp=10", got.size()); end
    for (int k = 0; k < got.size() && k < 10; k++) begin
      n_checks++; if (got[k] !== 9'(k + 1)) begin n_fail++; $display("FAIL stream_data_%0d got=%h exp=%h", k, got[k], 9'(k + 1)); end
    end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_saturate_clear();
    for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 1'($urandom), 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 8'($urandom), 1'($urandom), 0, 0);
    n_checks++; if (bus.drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_count got=%0d exp=255", bus.drop_count); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow got=%b exp=1", bus.overflow); end
    cycle(1, 8'hEE, 0, 0, 1);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL clr_drop_overflow got=%b exp=1", bus.overflow); end
    n_checks++; if (bus.drop_count !== 8'd1) begin n_fail++; $display("FAIL clr_drop_count got=%0d exp=1", bus.drop_count); end
    cycle(0, 8'h00, 0, 0, 1);
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got=%b exp=0", bus.overflow); end
    n_checks++; if (bus.drop_count !== 8'd0) begin n_fail++; $display("FAIL clr_count got=%0d exp=0", bus.drop_count); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_data !== m_head()) begin n_fail++; $display("FAIL sat_drain_%0d got=%h exp=%h", i, bus.out_data, m_head()); end
      cycle(0, 8'h00, 0, 1, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 29) == 0));
      n_checks++; if (bus.out_data !== m_head()) begin n_fail++; $display("FAIL rnd_data_%0d got=%h exp=%h", i, bus.out_data, m_head()); end
      n_checks++; if (bus.level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_level_%0d got=%0d exp=%0d", i, bus.level, mq.size()); end
      n_checks++; if ({bus.out_valid, bus.empty, bus.full} !== {mq.size() > 0, mq.size() == 0, mq.size() == DEPTH}) begin
        n_fail++; $display("FAIL rnd_status_%0d got=%b%b%b exp=%b%b%b", i, bus.out_valid, bus.empty, bus.full,
                          mq.size() > 0, mq.size() == 0, mq.size() == DEPTH);
      end
      n_checks++; if ({bus.overflow, bus.drop_count} !== {m_ovf, 8'(m_cnt)}) begin
        n_fail++; $display("FAIL rnd_drop_%0d got=%b/%0d exp=%b/%0d", i, bus.overflow, bus.drop_count, m_ovf, m_cnt);
      end
    end
  endtask

  initial begin
    bus.in_ready = 1'b0; bus.in_sum = '0; bus.in_carry = 1'b0;
    bus.out_take = 1'b0; bus.clr_overflow = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_fill_drop();
    test_full_push_pop();
    test_stream();
    test_saturate_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
